// File: rtl/bcd_serial_adder_pkg.sv
// bcd_serial_adder_pkg: shared BCD constants and the serial adder FSM state encoding
package bcd_serial_adder_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_BASE = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: start/done operand bus; err only exists with BCD_INVALID_DETECT_EN
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
  logic start;
  logic [4*DIGITS-1:0] a, b, sum;
  logic ready, busy, done, cout;
`ifdef BCD_INVALID_DETECT_EN
  logic err;
  modport master (output start, a, b, input ready, busy, done, sum, cout, err);
  modport slave (input start, a, b, output ready, busy, done, sum, cout, err);
`else
  modport master (output start, a, b, input ready, busy, done, sum, cout);
  modport slave (input start, a, b, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// bcd_digit_add: single-digit BCD add with decimal carry; inv flags a non-BCD input with BCD_INVALID_DETECT_EN
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   cout
`ifdef BCD_INVALID_DETECT_EN
  ,
  output logic                   inv
`endif
);
  logic [BCD_DIGIT_W:0] s;
  assign s = (BCD_DIGIT_W+1)'(a_d) + (BCD_DIGIT_W+1)'(b_d) + (BCD_DIGIT_W+1)'(cin);
  assign cout = s > (BCD_DIGIT_W+1)'(BCD_MAX);
  assign d = cout ? BCD_DIGIT_W'(s - (BCD_DIGIT_W+1)'(BCD_BASE)) : s[BCD_DIGIT_W-1:0];
`ifdef BCD_INVALID_DETECT_EN
  assign inv = a_d > BCD_DIGIT_W'(BCD_MAX) || b_d > BCD_DIGIT_W'(BCD_MAX);
`endif
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: adds two packed-BCD operands one digit per clock, LSD first
// Optional macro BCD_INVALID_DETECT_EN adds a sticky err flag for non-BCD operand digits.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_serial_adder_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int W = BCD_DIGIT_W * DIGITS;
  state_t state, state_nxt;
  logic [W-1:0] a_q, b_q, sum_q;
  logic [IW-1:0] idx;
  logic [BCD_DIGIT_W-1:0] d;
  logic carry, cout_q, d_cout, last, accept;
`ifdef BCD_INVALID_DETECT_EN
  logic inv, err_q;
`endif
  assign accept = bus.start && state != ADD;
  assign last = idx == IW'(DIGITS - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == ADD ? (last ? DONE : ADD) : (bus.start ? ADD : IDLE);
  end
  // operands shift right so the digit being added is always in the low nibble
  bcd_digit_add u_digit (
    .a_d(a_q[BCD_DIGIT_W-1:0]),
    .b_d(b_q[BCD_DIGIT_W-1:0]),
    .cin(carry),
    .d(d),
    .cout(d_cout)
`ifdef BCD_INVALID_DETECT_EN
    ,
    .inv(inv)
`endif
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx <= '0;
      carry <= 1'b0;
      cout_q <= 1'b0;
`ifdef BCD_INVALID_DETECT_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        sum_q <= '0;
        idx <= '0;
        carry <= 1'b0;
        cout_q <= 1'b0;
`ifdef BCD_INVALID_DETECT_EN
        err_q <= 1'b0;
`endif
      end else if (state == ADD) begin
        a_q <= a_q >> BCD_DIGIT_W;
        b_q <= b_q >> BCD_DIGIT_W;
        sum_q[BCD_DIGIT_W*idx +: BCD_DIGIT_W] <= d;
        idx <= idx + 1'b1;
        carry <= d_cout;
        if (last) cout_q <= d_cout;
`ifdef BCD_INVALID_DETECT_EN
        err_q <= err_q | inv;
`endif
      end
    end
  end
  assign bus.ready = state != ADD;
  assign bus.busy = state == ADD;
  assign bus.done = state == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
`ifdef BCD_INVALID_DETECT_EN
  assign bus.err = err_q;
`endif
endmodule
